// File: rtl/mc_ctrl_fsm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mc_ctrl_fsm_pkg                                                |
// | Purpose : Shared encodings for the multi-cycle MIPS control sequencer:   |
// |           opcodes, state codes, datapath mux encodings and the bundle    |
// |           of control outputs.                                            |
// | Ports   : none (package)                                                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package mc_ctrl_fsm_pkg;

   // Opcode field IR[31:26]
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   // ALU operation select
   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   // ALU B operand select
   localparam logic [1:0] ALUSRCB_B      = 2'b00;
   localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
   localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
   localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

   // PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Sequential state encoding, visible on state_o
   typedef enum logic [3:0] {
      S_IF  = 4'd0,
      S_ID  = 4'd1,
      S_EXR = 4'd2,
      S_EXI = 4'd3,
      S_EXM = 4'd4,
      S_EXB = 4'd5,
      S_EXJ = 4'd6,
      S_MRD = 4'd7,
      S_MWR = 4'd8,
      S_WBR = 4'd9,
      S_WBI = 4'd10,
      S_WBM = 4'd11
   } state_t;

   // All control outputs except the debug state code
   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       pc_en;
      logic       ir_en;
      logic       mdr_en;
      logic       ab_en;
      logic       aluout_en;
      logic       rf_we;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
      logic       illegal_op;
      logic       bus_err;
   } ctrl_t;

   // States that own an outstanding memory request
   function automatic logic is_wait_state(input state_t s);
      return (s == S_IF) || (s == S_MRD) || (s == S_MWR);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_fsm_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mc_ctrl_fsm_if                                                 |
// | Purpose : Bundle between the control sequencer and the datapath/memory.  |
// | Ports   : master (sequencer) - in  opcode, zero, mem_ack                 |
// |                                out mem_req, mem_we, iord, register       |
// |                                    enables, rf_we, mux selects,          |
// |                                    illegal_op, bus_err, state_o          |
// |           slave (datapath)   - mirror of master                          |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface mc_ctrl_fsm_if;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ack;
   logic       mem_req;
   logic       mem_we;
   logic       iord;
   logic       pc_en;
   logic       ir_en;
   logic       mdr_en;
   logic       ab_en;
   logic       aluout_en;
   logic       rf_we;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] pc_src;
   logic       illegal_op;
   logic       bus_err;
   logic [3:0] state_o;

   modport master (
      input  opcode, zero, mem_ack,
      output mem_req, mem_we, iord, pc_en, ir_en, mdr_en, ab_en, aluout_en,
             rf_we, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
             illegal_op, bus_err, state_o
   );

   modport slave (
      output opcode, zero, mem_ack,
      input  mem_req, mem_we, iord, pc_en, ir_en, mdr_en, ab_en, aluout_en,
             rf_we, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
             illegal_op, bus_err, state_o
   );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl_fsm_mem_wait.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mc_mem_wait                                                    |
// | Purpose : Memory wait timer. Counts cycles spent waiting for mem_ack and |
// |           qualifies ack/timeout against the wait condition.              |
// | Ports   : clk, rst_n      clock, async active-low reset                  |
// |           wait_i          sequencer is in a memory wait state            |
// |           ack_i           raw memory acknowledge                         |
// |           ack_o           ack accepted in a wait state                   |
// |           tmo_o           last allowed cycle elapsed without ack         |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module mc_mem_wait #(
   parameter int TIMEOUT_CYC = 255,
   parameter int TW          = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic wait_i,
   input  logic ack_i,
   output logic ack_o,
   output logic tmo_o
);

   localparam logic [TW-1:0] C_LAST = TW'(TIMEOUT_CYC - 1);

   logic [TW-1:0] cnt_q, cnt_d;

   // Ack takes priority: a timeout is only flagged when no ack is present.
   // The counter returns to 0 whenever the wait ends (ack, timeout or not
   // waiting), so every entry into a wait state starts from zero, including
   // the IF -> IF retry after a timeout.
   always_comb begin
      ack_o = wait_i & ack_i;
      tmo_o = wait_i & ~ack_i & (cnt_q == C_LAST);
      cnt_d = '0;
      if (wait_i && !ack_i && !tmo_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mc_ctrl_fsm                                                    |
// | Purpose : Multi-cycle control sequencer for the MIPS core. Drives the    |
// |           register enables, register-file write strobe, datapath mux     |
// |           selects and the single req/ack memory port.                    |
// | Ports   : clk    rising-edge clock                                       |
// |           rst_n  asynchronous active-low reset                           |
// |           bus    mc_ctrl_fsm_if.master (decoder/ALU inputs, memory       |
// |                  handshake, all control outputs, state_o)                |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module mc_ctrl_fsm
   import mc_ctrl_fsm_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255,
   parameter int TW          = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   mc_ctrl_fsm_if.master   bus
);

   state_t state_q, state_d;
   ctrl_t  w_ctrl;
   ctrl_t  w_ctrl_out;
   logic   w_wait;
   logic   w_ack;
   logic   w_tmo;

   assign w_wait = is_wait_state(state_q);

   mc_mem_wait #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .TW          (TW)
   ) u_mem_wait (
      .clk    (clk),
      .rst_n  (rst_n),
      .wait_i (w_wait),
      .ack_i  (bus.mem_ack),
      .ack_o  (w_ack),
      .tmo_o  (w_tmo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IF;
      end else begin
         state_q <= state_d;
      end
   end

   // Moore decode from state_q; pc_en/ir_en in IF and mdr_en in MRD follow
   // the qualified ack in the same cycle.
   always_comb begin
      state_d = state_q;
      w_ctrl  = '0;
      case (state_q)
         S_IF: begin
            w_ctrl.mem_req   = 1'b1;
            w_ctrl.alu_src_b = ALUSRCB_FOUR;
            w_ctrl.alu_op    = ALU_OP_ADD;
            w_ctrl.pc_src    = PCSRC_ALU;
            if (w_ack) begin
               w_ctrl.pc_en = 1'b1;
               w_ctrl.ir_en = 1'b1;
               state_d      = S_ID;
            end else if (w_tmo) begin
               // Retry the fetch from the same, unadvanced PC
               w_ctrl.bus_err = 1'b1;
               state_d        = S_IF;
            end
         end
         S_ID: begin
            w_ctrl.ab_en     = 1'b1;
            w_ctrl.aluout_en = 1'b1;
            w_ctrl.alu_src_b = ALUSRCB_IMM_SH;
            w_ctrl.alu_op    = ALU_OP_ADD;
            case (bus.opcode)
               OP_RTYPE:      state_d = S_EXR;
               OP_LW, OP_SW:  state_d = S_EXM;
               OP_BEQ:        state_d = S_EXB;
               OP_J:          state_d = S_EXJ;
               OP_ADDI:       state_d = S_EXI;
               default: begin
                  w_ctrl.illegal_op = 1'b1;
                  state_d           = S_IF;
               end
            endcase
         end
         S_EXR: begin
            w_ctrl.alu_src_a = 1'b1;
            w_ctrl.alu_src_b = ALUSRCB_B;
            w_ctrl.alu_op    = ALU_OP_FUNCT;
            w_ctrl.aluout_en = 1'b1;
            state_d          = S_WBR;
         end
         S_EXI, S_EXM: begin
            w_ctrl.alu_src_a = 1'b1;
            w_ctrl.alu_src_b = ALUSRCB_IMM;
            w_ctrl.alu_op    = ALU_OP_ADD;
            w_ctrl.aluout_en = 1'b1;
            if (state_q == S_EXI) begin
               state_d = S_WBI;
            end else if (bus.opcode == OP_LW) begin
               state_d = S_MRD;
            end else begin
               state_d = S_MWR;
            end
         end
         S_EXB: begin
            w_ctrl.alu_src_a = 1'b1;
            w_ctrl.alu_src_b = ALUSRCB_B;
            w_ctrl.alu_op    = ALU_OP_SUB;
            w_ctrl.pc_src    = PCSRC_ALUOUT;
            w_ctrl.pc_en     = bus.zero;
            state_d          = S_IF;
         end
         S_EXJ: begin
            w_ctrl.pc_src = PCSRC_JUMP;
            w_ctrl.pc_en  = 1'b1;
            state_d       = S_IF;
         end
         S_MRD: begin
            w_ctrl.mem_req = 1'b1;
            w_ctrl.iord    = 1'b1;
            if (w_ack) begin
               w_ctrl.mdr_en = 1'b1;
               state_d       = S_WBM;
            end else if (w_tmo) begin
               w_ctrl.bus_err = 1'b1;
               state_d        = S_IF;
            end
         end
         S_MWR: begin
            w_ctrl.mem_req = 1'b1;
            w_ctrl.mem_we  = 1'b1;
            w_ctrl.iord    = 1'b1;
            if (w_ack) begin
               state_d = S_IF;
            end else if (w_tmo) begin
               w_ctrl.bus_err = 1'b1;
               state_d        = S_IF;
            end
         end
         S_WBR: begin
            w_ctrl.rf_we   = 1'b1;
            w_ctrl.reg_dst = 1'b1;
            state_d        = S_IF;
         end
         S_WBI: begin
            w_ctrl.rf_we = 1'b1;
            state_d      = S_IF;
         end
         S_WBM: begin
            w_ctrl.rf_we      = 1'b1;
            w_ctrl.mem_to_reg = 1'b1;
            state_d           = S_IF;
         end
         default: begin
            state_d = S_IF;
         end
      endcase
   end

   // While reset is asserted the state register already reads IF, which
   // would request memory; force every control low so an in-flight request
   // drops immediately, without waiting for a clock edge.
   assign w_ctrl_out = rst_n ? w_ctrl : '0;

   assign bus.mem_req    = w_ctrl_out.mem_req;
   assign bus.mem_we     = w_ctrl_out.mem_we;
   assign bus.iord       = w_ctrl_out.iord;
   assign bus.pc_en      = w_ctrl_out.pc_en;
   assign bus.ir_en      = w_ctrl_out.ir_en;
   assign bus.mdr_en     = w_ctrl_out.mdr_en;
   assign bus.ab_en      = w_ctrl_out.ab_en;
   assign bus.aluout_en  = w_ctrl_out.aluout_en;
   assign bus.rf_we      = w_ctrl_out.rf_we;
   assign bus.reg_dst    = w_ctrl_out.reg_dst;
   assign bus.mem_to_reg = w_ctrl_out.mem_to_reg;
   assign bus.alu_src_a  = w_ctrl_out.alu_src_a;
   assign bus.alu_src_b  = w_ctrl_out.alu_src_b;
   assign bus.alu_op     = w_ctrl_out.alu_op;
   assign bus.pc_src     = w_ctrl_out.pc_src;
   assign bus.illegal_op = w_ctrl_out.illegal_op;
   assign bus.bus_err    = w_ctrl_out.bus_err;
   assign bus.state_o    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_mc_ctrl_fsm                                                 |
// | Purpose : Self-checking bench for mc_ctrl_fsm (TIMEOUT_CYC = 4).         |
// |           Directed vector table, randomized instruction stream against   |
// |           an instruction-level reference model, and reset corner cases.  |
// | Ports   : none                                                           |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_mc_ctrl_fsm;

   localparam int T = 4;

   // Expected-output vector layout:
   // [23] mem_req [22] mem_we [21] iord [20] pc_en [19] ir_en [18] mdr_en
   // [17] ab_en [16] aluout_en [15] rf_we [14] reg_dst [13] mem_to_reg
   // [12] alu_src_a [11:10] alu_src_b [9:8] alu_op [7:6] pc_src
   // [5] illegal_op [4] bus_err [3:0] state_o
   localparam logic [23:0] REQ  = 24'h800000;
   localparam logic [23:0] WE   = 24'h400000;
   localparam logic [23:0] IORD = 24'h200000;
   localparam logic [23:0] PC   = 24'h100000;
   localparam logic [23:0] IR   = 24'h080000;
   localparam logic [23:0] MDR  = 24'h040000;
   localparam logic [23:0] AB   = 24'h020000;
   localparam logic [23:0] ALO  = 24'h010000;
   localparam logic [23:0] RF   = 24'h008000;
   localparam logic [23:0] RD   = 24'h004000;
   localparam logic [23:0] M2R  = 24'h002000;
   localparam logic [23:0] ASA  = 24'h001000;
   localparam logic [23:0] ILL  = 24'h000020;
   localparam logic [23:0] BERR = 24'h000010;

   function automatic logic [23:0] asb(input int v);  return 24'(v) << 10; endfunction
   function automatic logic [23:0] aop(input int v);  return 24'(v) << 8;  endfunction
   function automatic logic [23:0] psrc(input int v); return 24'(v) << 6;  endfunction

   // Per-state expectations built from the control table
   localparam logic [23:0] V_IF  = REQ | (24'd1 << 10) | 24'd0;
   localparam logic [23:0] V_ID  = AB | ALO | (24'd3 << 10) | 24'd1;
   localparam logic [23:0] V_EXR = ASA | ALO | (24'd2 << 8) | 24'd2;
   localparam logic [23:0] V_EXI = ASA | ALO | (24'd2 << 10) | 24'd3;
   localparam logic [23:0] V_EXM = ASA | ALO | (24'd2 << 10) | 24'd4;
   localparam logic [23:0] V_EXB = ASA | (24'd1 << 8) | (24'd1 << 6) | 24'd5;
   localparam logic [23:0] V_EXJ = PC | (24'd2 << 6) | 24'd6;
   localparam logic [23:0] V_MRD = REQ | IORD | 24'd7;
   localparam logic [23:0] V_MWR = REQ | WE | IORD | 24'd8;
   localparam logic [23:0] V_WBR = RF | RD | 24'd9;
   localparam logic [23:0] V_WBI = RF | 24'd10;
   localparam logic [23:0] V_WBM = RF | M2R | 24'd11;

   typedef struct {
      logic [5:0]  op;
      logic        zero;
      logic        ack;
      logic [23:0] exp;
      string       name;
   } vec_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   vec_t q[$];

   mc_ctrl_fsm_if bus ();

   mc_ctrl_fsm #(
      .TIMEOUT_CYC (T),
      .TW          (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [23:0] w_act;
   assign w_act = {bus.mem_req, bus.mem_we, bus.iord, bus.pc_en, bus.ir_en,
                   bus.mdr_en, bus.ab_en, bus.aluout_en, bus.rf_we, bus.reg_dst,
                   bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                   bus.pc_src, bus.illegal_op, bus.bus_err, bus.state_o};

   task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %06h want %06h", name, act, exp);
      end
   endtask

   task automatic add(input logic [5:0] op, input logic zero, input logic ack,
                      input logic [23:0] exp, input string name);
      vec_t v;
      v.op = op; v.zero = zero; v.ack = ack; v.exp = exp; v.name = name;
      q.push_back(v);
   endtask

   task automatic run_queue();
      foreach (q[i]) begin
         @(negedge clk);
         bus.opcode  = q[i].op;
         bus.zero    = q[i].zero;
         bus.mem_ack = q[i].ack;
         #1;
         check($sformatf("%s[%0d]", q[i].name, i), w_act, q[i].exp);
      end
      q.delete();
   endtask

   // ---------------- reference model (instruction level) -----------------
   // A memory wait lasting 'delay' cycles before ack; ack arrives only if it
   // falls inside the T-cycle window, otherwise the last window cycle flags
   // bus_err. Returns whether the transfer completed.
   task automatic m_wait(input int delay, input logic [23:0] base,
                         input logic [23:0] on_ack, input logic [5:0] op,
                         input string nm, output bit acked);
      acked = 1'b0;
      for (int c = 0; c < T; c++) begin
         if (c == delay) begin
            add(op, 1'($urandom), 1'b1, base | on_ack, nm);
            acked = 1'b1;
            return;
         end else if (c == T - 1) begin
            add(op, 1'($urandom), 1'b0, base | BERR, nm);
            return;
         end else begin
            add(op, 1'($urandom), 1'b0, base, nm);
         end
      end
   endtask

   task automatic m_instr(input logic [5:0] op);
      bit   ok;
      logic z;
      // Fetch, retried from the same PC until it completes
      do begin
         m_wait($urandom_range(0, 5), V_IF, PC | IR, 6'($urandom), "r_if", ok);
      end while (!ok);
      case (op)
         6'h00: begin
            add(op, 1'($urandom), 1'($urandom), V_ID, "r_id");
            add(op, 1'($urandom), 1'($urandom), V_EXR, "r_exr");
            add(op, 1'($urandom), 1'($urandom), V_WBR, "r_wbr");
         end
         6'h08: begin
            add(op, 1'($urandom), 1'($urandom), V_ID, "r_id");
            add(op, 1'($urandom), 1'($urandom), V_EXI, "r_exi");
            add(op, 1'($urandom), 1'($urandom), V_WBI, "r_wbi");
         end
         6'h23: begin
            add(op, 1'($urandom), 1'($urandom), V_ID, "r_id");
            add(op, 1'($urandom), 1'($urandom), V_EXM, "r_exm");
            m_wait($urandom_range(0, 5), V_MRD, MDR, op, "r_mrd", ok);
            if (ok) add(op, 1'($urandom), 1'($urandom), V_WBM, "r_wbm");
         end
         6'h2b: begin
            add(op, 1'($urandom), 1'($urandom), V_ID, "r_id");
            add(op, 1'($urandom), 1'($urandom), V_EXM, "r_exm");
            m_wait($urandom_range(0, 5), V_MWR, 24'h0, op, "r_mwr", ok);
         end
         6'h04: begin
            z = 1'($urandom);
            add(op, 1'($urandom), 1'($urandom), V_ID, "r_id");
            add(op, z, 1'($urandom), V_EXB | (z ? PC : 24'h0), "r_exb");
         end
         6'h02: begin
            add(op, 1'($urandom), 1'($urandom), V_ID, "r_id");
            add(op, 1'($urandom), 1'($urandom), V_EXJ, "r_exj");
         end
         default: begin
            add(op, 1'($urandom), 1'($urandom), V_ID | ILL, "r_ill");
         end
      endcase
   endtask

   function automatic logic [5:0] pick_op();
      logic [5:0] o;
      case ($urandom_range(0, 6))
         0: return 6'h00;
         1: return 6'h08;
         2: return 6'h23;
         3: return 6'h2b;
         4: return 6'h04;
         5: return 6'h02;
         default: begin
            o = 6'($urandom);
            while (o inside {6'h00, 6'h08, 6'h23, 6'h2b, 6'h04, 6'h02}) o = 6'($urandom);
            return o;
         end
      endcase
   endfunction

   // --------------------------------------------------------------------------
   initial begin
      total       = 0;
      bad         = 0;
      rst_n       = 1'b0;
      bus.opcode  = 6'h00;
      bus.zero    = 1'b0;
      bus.mem_ack = 1'b0;

      // Reset held with mem_ack toggling: everything stays low
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.mem_ack = ~bus.mem_ack;
         #1;
         check("reset_outputs", w_act, 24'h0);
      end

      // Release: request is up in the very first cycle
      @(negedge clk);
      bus.mem_ack = 1'b0;
      rst_n       = 1'b1;
      #1;
      check("first_req", w_act, V_IF);

      // ---------------- directed table ----------------
      // R-type, zero-wait
      add(6'h3f, 0, 1, V_IF | PC | IR, "rt_if");
      add(6'h00, 0, 0, V_ID, "rt_id");
      add(6'h00, 0, 0, V_EXR, "rt_exr");
      add(6'h00, 0, 0, V_WBR, "rt_wbr");
      add(6'h00, 0, 0, V_IF, "rt_next_if");
      // beq taken
      add(6'h00, 0, 1, V_IF | PC | IR, "bq1_if");
      add(6'h04, 0, 0, V_ID, "bq1_id");
      add(6'h04, 1, 0, V_EXB | PC, "bq1_exb");
      // beq not taken
      add(6'h04, 0, 1, V_IF | PC | IR, "bq0_if");
      add(6'h04, 1, 0, V_ID, "bq0_id");
      add(6'h04, 0, 0, V_EXB, "bq0_exb");
      // j
      add(6'h00, 0, 1, V_IF | PC | IR, "j_if");
      add(6'h02, 0, 0, V_ID, "j_id");
      add(6'h02, 0, 1, V_EXJ, "j_exj");
      // illegal opcode
      add(6'h00, 0, 1, V_IF | PC | IR, "ill_if");
      add(6'h3f, 0, 0, V_ID | ILL, "ill_id");
      add(6'h3f, 0, 0, V_IF, "ill_back_if");
      // lw with ack delayed 3 cycles in MRD
      add(6'h00, 0, 1, V_IF | PC | IR, "lw_if");
      add(6'h23, 0, 0, V_ID, "lw_id");
      add(6'h23, 0, 0, V_EXM, "lw_exm");
      add(6'h23, 0, 0, V_MRD, "lw_mrd0");
      add(6'h23, 0, 0, V_MRD, "lw_mrd1");
      add(6'h23, 0, 0, V_MRD, "lw_mrd2");
      add(6'h23, 0, 1, V_MRD | MDR, "lw_mrd_ack");
      add(6'h23, 0, 0, V_WBM, "lw_wbm");
      // sw timing out in MWR
      add(6'h00, 0, 1, V_IF | PC | IR, "swt_if");
      add(6'h2b, 0, 0, V_ID, "swt_id");
      add(6'h2b, 0, 0, V_EXM, "swt_exm");
      add(6'h2b, 0, 0, V_MWR, "swt_mwr0");
      add(6'h2b, 0, 0, V_MWR, "swt_mwr1");
      add(6'h2b, 0, 0, V_MWR, "swt_mwr2");
      add(6'h2b, 0, 0, V_MWR | BERR, "swt_berr");
      add(6'h2b, 0, 0, V_IF, "swt_back_if");
      // sw with ack in the 4th cycle: ack wins
      add(6'h00, 0, 1, V_IF | PC | IR, "swa_if");
      add(6'h2b, 0, 0, V_ID, "swa_id");
      add(6'h2b, 0, 0, V_EXM, "swa_exm");
      add(6'h2b, 0, 0, V_MWR, "swa_mwr0");
      add(6'h2b, 0, 0, V_MWR, "swa_mwr1");
      add(6'h2b, 0, 0, V_MWR, "swa_mwr2");
      add(6'h2b, 0, 1, V_MWR, "swa_ack");
      // IF timeout then retry
      add(6'h00, 0, 0, V_IF, "ift0");
      add(6'h00, 0, 0, V_IF, "ift1");
      add(6'h00, 0, 0, V_IF, "ift2");
      add(6'h00, 0, 0, V_IF | BERR, "ift_berr");
      add(6'h00, 0, 0, V_IF, "ift_retry0");
      add(6'h00, 0, 1, V_IF | PC | IR, "ift_retry_ack");
      add(6'h08, 0, 1, V_ID, "addi_id");
      add(6'h08, 0, 1, V_EXI, "addi_exi");
      add(6'h08, 0, 1, V_WBI, "addi_wbi");
      run_queue();

      // ---------------- randomized instruction stream ----------------
      for (int n = 0; n < 150; n++) begin
         m_instr(pick_op());
      end
      run_queue();

      // ---------------- reset in the middle of an MRD wait ----------------
      add(6'h00, 0, 1, V_IF | PC | IR, "rm_if");
      add(6'h23, 0, 0, V_ID, "rm_id");
      add(6'h23, 0, 0, V_EXM, "rm_exm");
      add(6'h23, 0, 0, V_MRD, "rm_mrd");
      run_queue();
      @(negedge clk);
      bus.mem_ack = 1'b0;
      #1;
      check("rm_mrd_wait", w_act, V_MRD);
      #1;
      rst_n = 1'b0;
      #1;
      check("rm_async_drop", w_act, 24'h0);
      @(negedge clk);
      bus.mem_ack = 1'b1;
      #1;
      check("rm_held", w_act, 24'h0);
      @(negedge clk);
      bus.mem_ack = 1'b0;
      rst_n       = 1'b1;
      #1;
      check("rm_release", w_act, V_IF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
